// File: rtl/bswap_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : bswap_stream_engine
// Description : Streams a block of words from a synchronous read port to a
//               write port, byte-permuting each word on the way. One word
//               per cycle, start/busy/done handshake, optional in-place use.
// Revision    : 1.0 - initial release
// ============================================================================
module bswap_stream_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data
);

    localparam int c_NB = DATA_W / 8;
    localparam int c_NH = DATA_W / 16;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [1:0] c_MODE_REV   = 2'b00;
    localparam logic [1:0] c_MODE_HREV  = 2'b01;
    localparam logic [1:0] c_MODE_BSWAP = 2'b10;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [1:0]        r_mode;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              w_accept;
    logic              w_last;
    logic [DATA_W-1:0] w_rev;
    logic [DATA_W-1:0] w_hrev;
    logic [DATA_W-1:0] w_bswap;
    logic [DATA_W-1:0] w_perm;

    assign w_accept = (r_state == c_ST_IDLE) && start;
    assign w_last   = (r_idx == r_len - LEN_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a zero-length request skips straight to DONE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next_state = (length == '0) ? c_ST_DONE : c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_last) begin
                    w_next_state = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: w_next_state = c_ST_DONE;
            c_ST_DONE:  w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // State-decoded handshake and read strobe
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
            end
            c_ST_DRAIN: busy = 1'b1;
            c_ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture; held constant for the whole run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= '0;
            r_src  <= '0;
            r_dst  <= '0;
            r_len  <= '0;
        end else if (w_accept) begin
            r_mode <= mode;
            r_src  <= src_base;
            r_dst  <= dst_base;
            r_len  <= length;
        end
    end

    // Word index: cleared outside RUN, advances once per issued read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (r_state == c_ST_RUN) begin
            r_idx <= r_idx + LEN_W'(1);
        end else begin
            r_idx <= '0;
        end
    end

    // Write pipeline: each write trails its read by exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            r_wr_en   <= mem_rd_en;
            r_wr_addr <= r_dst + ADDR_W'(r_idx);
        end
    end

    // Byte-reverse the full word
    for (genvar k = 0; k < c_NB; k++) begin : g_byte_rev
        assign w_rev[8*k +: 8] = mem_rd_data[8*(c_NB-1-k) +: 8];
    end

    // Reverse halfword order, keeping bytes inside each halfword
    for (genvar h = 0; h < c_NH; h++) begin : g_half_rev
        assign w_hrev[16*h +: 16] = mem_rd_data[16*(c_NH-1-h) +: 16];
    end

    // Swap the two bytes of every halfword
    for (genvar h = 0; h < c_NH; h++) begin : g_half_bswap
        assign w_bswap[16*h +: 8]   = mem_rd_data[16*h+8 +: 8];
        assign w_bswap[16*h+8 +: 8] = mem_rd_data[16*h +: 8];
    end

    // Permutation select on the memory's registered read data
    always_comb begin
        w_perm = mem_rd_data;
        case (r_mode)
            c_MODE_REV:   w_perm = w_rev;
            c_MODE_HREV:  w_perm = w_hrev;
            c_MODE_BSWAP: w_perm = w_bswap;
            default:      w_perm = mem_rd_data;
        endcase
    end

    // Address/data outputs are forced to zero whenever their strobe is low
    assign mem_rd_addr = mem_rd_en ? (r_src + ADDR_W'(r_idx)) : '0;
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_addr = r_wr_en ? r_wr_addr : '0;
    assign mem_wr_data = r_wr_en ? w_perm : '0;

endmodule
`default_nettype wire

// File: doc/bswap_stream_engine.md
Name: bswap_stream_engine

Overview:
- Sequential, parametrised successor to the combinational in-place u32 byte-swap routine.
- Walks a block of words through a synchronous single-port-read / single-port-write memory interface and writes each word back byte-permuted. The destination may be a separate region or the source region (in place).
- Four selectable permutation modes, generic word width, one word per cycle throughput, start/busy/done handshake.
- Sits beside the execution environment's u32 store as a DMA-style helper driven by the operation sequencer.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 16 and ≥16.
- ADDR_W, 16, word address width; addresses wrap modulo 2^ADDR_W.
- LEN_W, 16, width of the length field in words.

Ports:
- clk, input, 1, system clock; all logic is rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request; sampled only in IDLE.
- mode, input, 2, permutation: 00 reverse all bytes, 01 reverse halfword order, 10 swap bytes within each halfword, 11 plain copy.
- src_base, input, ADDR_W, first source word address.
- dst_base, input, ADDR_W, first destination word address.
- length, input, LEN_W, number of words to process.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse when the last write has been issued.
- mem_rd_en, output, 1, read request.
- mem_rd_addr, output, ADDR_W, read address.
- mem_rd_data, input, DATA_W, read data; valid exactly 1 cycle after mem_rd_en.
- mem_wr_en, output, 1, write strobe.
- mem_wr_addr, output, ADDR_W, write address.
- mem_wr_data, output, DATA_W, permuted write data.

Behaviour:
- Reset: on rst_n low, asynchronously clear busy, done, mem_rd_en, mem_wr_en, all address and data outputs, internal counters and the FSM. Go to IDLE. Reset mid-run abandons the transfer; no further writes are issued.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start, latch mode, src_base, dst_base and length.
  - If length==0, go to DONE; no memory access occurs.
  - Otherwise go to RUN.
- RUN:
  - Issue the read of src_base+i on cycle i (i=0..length-1 counted from the first RUN cycle).
  - After issuing i=length-1, go to DRAIN.
- Write pipeline (active in RUN and DRAIN): one cycle after each read, assert mem_wr_en with mem_wr_addr = dst_base+i and mem_wr_data = perm(mem_rd_data, latched mode).
- DRAIN: lasts 1 cycle, covering the final write, then go to DONE.
- DONE: assert done for 1 cycle, drop busy, return to IDLE.
- Timing: with start accepted on edge 0, reads occur on cycles 1..N, writes on cycles 2..N+1, and done is high on cycle N+2. For N=0, done is high on cycle 1. The next start is accepted no earlier than the cycle after done.
- start while busy or done is high is ignored; the latched operands stay stable for the whole run.
- Address arithmetic is modulo 2^ADDR_W: src_base+i and dst_base+i wrap silently.
- The length counter is LEN_W bits wide; length = 2^LEN_W-1 is supported.
- Overlap: exact in-place (src_base==dst_base) is defined and correct, because a read of word i never collides with the write of word i-1. Any other overlapping source/destination ranges give undefined data. The block gives no protection against this.
- perm, with word bytes indexed B0 = least significant:
  - 00: byte k → byte (DATA_W/8-1-k).
  - 01: halfword k → halfword (DATA_W/16-1-k), byte order inside each halfword kept.
  - 10: within each halfword, swap its two bytes.
  - 11: identity.
  - perm is purely combinational on the registered read data; no extra latency.

Test Plan:
- In-place, mode 00, src=dst=0x10, N=2, mem[0x10]=0x11223344, mem[0x11]=0xAABBCCDD → writes 0x44332211@0x10 and 0xDDCCBBAA@0x11 on cycles 2 and 3; done on cycle 4; busy high on cycles 1–3.
- Modes 01/10/11, N=1, src=0x0, dst=0x100, word 0x11223344 → writes 0x33441122, 0x22114433 and 0x11223344 respectively @0x100; source left untouched.
- length=0 with start → done on cycle 1, no mem_rd_en/mem_wr_en ever asserted; start pulsed again while done is high → ignored.
- Wrap: src=0xFFFE, dst=0x0010, N=4 → reads 0xFFFE, 0xFFFF, 0x0000, 0x0001 and writes 0x0010–0x0013 in order.
- Back-to-back throughput: N=8 → mem_rd_en high for exactly 8 consecutive cycles, mem_wr_en for 8 consecutive cycles offset by 1; start toggled mid-run has no effect.
- Reset mid-run: N=16, rst_n low after the 5th write → all outputs 0 immediately and asynchronously; after release the FSM is in IDLE; a new start with N=1 completes normally.
